// File: rtl/dog_pkg.sv
// Shared definitions for the DoG window generator and the extrema detector.
package dog_pkg;

  localparam int unsigned DW         = 8;
  localparam int unsigned NUM_TAPS   = 27;
  localparam int unsigned CENTRE_TAP = 13;

  typedef logic [NUM_TAPS-1:0][DW-1:0] win_t;

  // s = scale, r = row (0 oldest), c = column (0 oldest)
  function automatic int unsigned tap_idx(input int unsigned s,
                                          input int unsigned r,
                                          input int unsigned c);
    return s * 9 + r * 3 + c;
  endfunction

endpackage

// File: rtl/dog_line_buffer.sv
// Two-row line buffer for one scale: read-before-write, row y-1 ages into row y-2.
module dog_line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 10
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_row1,
  output logic [DW-1:0] o_row2
);

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  logic [DW-1:0] row1_q, row1_d, row2_q, row2_d;

  // RAM contents are never cleared; stale rows only reach suppressed windows
  always_ff @(posedge iclk) begin
    if (i_we) begin
      mem1[i_addr] <= i_din;
      mem2[i_addr] <= mem1[i_addr];
    end
  end

  always_comb begin
    row1_d = row1_q;
    row2_d = row2_q;
    if (i_we) begin
      row1_d = mem1[i_addr];
      row2_d = mem2[i_addr];
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      row1_q <= '0;
      row2_q <= '0;
    end else begin
      row1_q <= row1_d;
      row2_q <= row2_d;
    end
  end

  assign o_row1 = row1_q;
  assign o_row2 = row2_q;

endmodule

// File: rtl/dog_window_gen.sv
// 3x3x3 scale-space neighbourhood window builder for DoG extrema detection.
module dog_window_gen #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned DW    = 8
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             iDval,
  input  logic             iSof,
  input  logic [DW-1:0]    iDog0,
  input  logic [DW-1:0]    iDog1,
  input  logic [DW-1:0]    iDog2,
  output logic             oDval,
  output logic [DW-1:0]    oData_a,
  output logic [27*DW-1:0] oWin,
  output logic [15:0]      oX,
  output logic [15:0]      oY
);
  import dog_pkg::*;

  localparam int unsigned CW = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DW-1:0] dog_in [NS];
  logic [DW-1:0] row1 [NS];
  logic [DW-1:0] row2 [NS];

  logic [CW-1:0] pos_x_c, pos_y_c;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [DW-1:0] s1_pix_q [NS];
  logic [DW-1:0] s1_pix_d [NS];

  logic          s2_vld_q, s2_vld_d;
  logic [CW-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic [DW-1:0] win_q [NS][3][3];
  logic [DW-1:0] win_d [NS][3][3];

  logic             odval_q, odval_d;
  logic [DW-1:0]    odata_q, odata_d;
  logic [27*DW-1:0] owin_q, owin_d;
  logic [CW-1:0]    ox_q, ox_d, oy_q, oy_d;

  assign dog_in[0] = iDog0;
  assign dog_in[1] = iDog1;
  assign dog_in[2] = iDog2;

  // Position of the pixel being accepted; start of frame overrides the counters
  always_comb begin
    pos_x_c = (iDval && iSof) ? '0 : x_q;
    pos_y_c = (iDval && iSof) ? '0 : y_q;
    x_d     = x_q;
    y_d     = y_q;
    if (iDval) begin
      if (pos_x_c == CW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (pos_y_c == CW'(IMG_H - 1)) ? '0 : pos_y_c + CW'(1);
      end else begin
        x_d = pos_x_c + CW'(1);
        y_d = pos_y_c;
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_lb
    dog_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(AW)) u_lb (
      .iclk   (iclk),
      .irst_n (irst_n),
      .i_we   (iDval),
      .i_addr (AW'(pos_x_c)),
      .i_din  (dog_in[s]),
      .o_row1 (row1[s]),
      .o_row2 (row2[s])
    );
  end

  // Pipeline: stage 1 aligns input with RAM read, stage 2 shifts windows, then output
  always_comb begin
    s1_vld_d = iDval;
    s1_x_d   = s1_x_q;
    s1_y_d   = s1_y_q;
    s1_pix_d = s1_pix_q;
    if (iDval) begin
      s1_x_d   = pos_x_c;
      s1_y_d   = pos_y_c;
      s1_pix_d = dog_in;
    end

    s2_vld_d = s1_vld_q && (s1_x_q >= CW'(2)) && (s1_y_q >= CW'(2));
    s2_x_d   = s2_x_q;
    s2_y_d   = s2_y_q;
    win_d    = win_q;
    if (s1_vld_q) begin
      s2_x_d = s1_x_q - CW'(1);
      s2_y_d = s1_y_q - CW'(1);
      for (int unsigned s = 0; s < NS; s++) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_d[s][r][0] = win_q[s][r][1];
          win_d[s][r][1] = win_q[s][r][2];
        end
        win_d[s][0][2] = row2[s];
        win_d[s][1][2] = row1[s];
        win_d[s][2][2] = s1_pix_q[s];
      end
    end

    odval_d = s2_vld_q;
    owin_d  = owin_q;
    odata_d = odata_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    if (s2_vld_q) begin
      for (int unsigned s = 0; s < NS; s++)
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            owin_d[tap_idx(s, r, c)*DW +: DW] = win_q[s][r][c];
      odata_d = owin_d[CENTRE_TAP*DW +: DW];
      ox_d    = s2_x_q;
      oy_d    = s2_y_q;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
      odval_q  <= 1'b0;
      odata_q  <= '0;
      owin_q   <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        s1_pix_q[s] <= '0;
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            win_q[s][r][c] <= '0;
      end
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      s1_vld_q <= s1_vld_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
      s1_pix_q <= s1_pix_d;
      s2_vld_q <= s2_vld_d;
      s2_x_q   <= s2_x_d;
      s2_y_q   <= s2_y_d;
      win_q    <= win_d;
      odval_q  <= odval_d;
      odata_q  <= odata_d;
      owin_q   <= owin_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
    end
  end

  assign oDval   = odval_q;
  assign oData_a = odata_q;
  assign oWin    = owin_q;
  assign oX      = ox_q;
  assign oY      = oy_q;

endmodule

// File: doc/dog_window_gen.md
# dog_window_gen

Builds the 3×3×3 neighbourhood window for scale-space extrema detection. Takes three pixel-aligned Difference-of-Gaussian streams in raster order, one per adjacent scale, and buffers two image rows per scale. Each accepted interior pixel yields one window: the 27 neighbour values plus the centre sample, tagged with the centre's coordinates. It sits directly upstream of the extrema detector; window tap k drives that detector's neighbour input k, and `oData_a` drives its centre input.

## Interface
- `IMG_W`, 640: pixels per row (≥ 3).
- `IMG_H`, 480: rows per frame (≥ 3).
- `DW`, 8: sample width.
- `iclk` input 1: clock.
- `irst_n` input 1: reset, asynchronous, active-low.
- `iDval` input 1: input pixel valid; one pixel per cycle on which it is high.
- `iSof` input 1: start of frame; sampled only with `iDval`, and marks that pixel as (0,0).
- `iDog0` input DW: lower scale sample.
- `iDog1` input DW: middle scale sample.
- `iDog2` input DW: upper scale sample.
- `oDval` output 1: window valid, a single-cycle strobe per window.
- `oData_a` output DW: centre sample, equal to tap 13.
- `oWin` output 27*DW: packed taps; tap k occupies bits [k*DW +: DW].
- `oX` output 16: window-centre column.
- `oY` output 16: window-centre row.

## Operation
- **Tap index:** k = s*9 + r*3 + c.
  - s is the scale (0 = `iDog0`).
  - r is the row (0 = oldest, i.e. y−2).
  - c is the column (0 = oldest, i.e. x−2).
- **Position counters:** x (0..IMG_W−1) and y (0..IMG_H−1) give the position of the pixel currently accepted.
  - They advance only on `iDval`.
  - At x = IMG_W−1, x wraps to 0 and y increments.
  - At (IMG_W−1, IMG_H−1), both wrap to 0.
  - `iDval`&`iSof` forces that pixel to (0,0), whatever the counter state.
- **Line buffers:** each scale has a two-row line buffer of depth IMG_W, addressed by x, using read-before-write.
  - The row-(y−1) and row-(y−2) samples at column x are read out.
  - The new sample is written, and the old row-(y−1) sample moves to row-(y−2).
- **Window registers:** each scale has a 3×3 shift register that shifts left by one column per accepted pixel. The new column is {row y−2, row y−1, incoming}.
- **Valid gating:** a window is emitted for accepted pixel (x,y) only when x ≥ 2 and y ≥ 2.
  - The centre is then (x−1, y−1), so border centres are never emitted.
  - Windows never mix columns across a row wrap.
- **Per-frame count:** exactly (IMG_W−2)·(IMG_H−2) windows per complete frame.
- **No clearing:** line buffers are never cleared. Stale data from the previous frame appears only in suppressed windows.
- **Idle / bubbles:** while `iDval` is low, no state changes. `oDval` is 0 and the data outputs hold their values.

## Timing
- **Latency:** 2 cycles. A pixel sampled at edge t whose window qualifies produces `oDval`=1 during the cycle after edge t+2.
  - Stage 1: registered RAM read plus the registered input and valid tag.
  - Stage 2: window shift and output register.
- **Pipeline advance:** stages advance every clock. The shift registers move only on stage-1 valid, so bubbles of any length or pattern are transparent.
- **Throughput:** 1 window per clock when `iDval` is continuously high.
- **Reset (asynchronous):** `oDval`=0, `oWin`=0, `oData_a`=0, `oX`=0, `oY`=0; x, y and valid tags are 0.
  - Reset mid-frame aborts the frame. The first pixel after release is (0,0).
- **`iSof` on an in-flight pipeline:** windows already in flight still complete. The first new-frame window appears after pixel (2,2) of the new frame.

## Structure
- **Shared package `dog_pkg`:**
  - `DW`;
  - `NUM_TAPS`=27;
  - `CENTRE_TAP`=13;
  - a tap-index function (s,r,c)→k;
  - the packed window type.

  The extrema detector uses the same package.
- **Sub-module `dog_line_buffer`:** holds one scale's two rows (inferred dual-port RAM, synchronous read). It is instantiated three times.
- **Top level:** the counters, valid gating, window registers and output registers.

## Test plan
Scenarios 1–4 and 6 use IMG_W=8, IMG_H=6.
1. **Ramp frame:** `iDog0`=y*8+x, `iDog1`=64+y*8+x, `iDog2`=128+y*8+x, continuous valid.
   - The first `oDval` comes 2 cycles after pixel (2,2), with `oX`=1, `oY`=1, `oData_a`=73, tap 0=0, tap 26=146.
   - Exactly 24 strobes per frame.
2. **Bubbles:** the same frame with random 50% `iDval` gives identical window contents and coordinates, 24 strobes, and no strobe without a new pixel.
3. **Row wrap:** pixels at x=0 and x=1 never strobe. The window at centre (1,3) has tap 9=64+16, i.e. no data carried over from row 1's tail.
4. **`iSof` mid-frame:** `iSof` pulsed at counter position (5,3) gives no `oDval` until the new frame's (2,2); the first window is centred at (1,1).
5. **Reset mid-frame:** assert `irst_n`=0 asynchronously.
   - All outputs go to 0 before the next edge.
   - After release, a full frame yields 24 correct windows.
6. **Back-to-back frames:** a second frame with values +1 gives no strobes during its rows 0–1, and every window holds only frame-2 values.
